vc_injection_arbiter: RTL and testbench

VC_INJECTION_ARBITER -- requirements
Module: vc_injection_arbiter

---
 rtl/vc_injection_arbiter_pkg.sv | 24 ++
 rtl/vc_injection_arbiter_if.sv | 28 ++
 rtl/vc_injection_arbiter_rr_priority_picker.sv | 32 +++
 rtl/vc_injection_arbiter.sv | 122 ++++++++++++
 tb/tb_vc_injection_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vc_injection_arbiter_pkg.sv
// Shared NoC definitions (noc_pkg): flit-type field location and codes,
// plus the packet-lock state type used when VC_PACKET_LOCK_EN is defined.
package noc_pkg;

  localparam int FLIT_TYPE_MSB = 31;
  localparam int FLIT_TYPE_LSB = 30;

  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  typedef enum logic {
    LOCK_IDLE,
    LOCK_LOCKED
  } lock_state_e;

  function automatic logic is_head(input logic [1:0] flit_type);
    return flit_type == FLIT_HEAD;
  endfunction

  function automatic logic is_tail(input logic [1:0] flit_type);
    return flit_type == FLIT_TAIL;
  endfunction

endpackage

// File: rtl/vc_injection_arbiter_if.sv
// Injection-port bundle: per-VC flit inputs toward the arbiter and the
// single registered flit stream toward the router input port.
interface vc_injection_arbiter_if #(
  parameter int VC         = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_W = $clog2(VC);

  logic [VC*DATA_WIDTH-1:0] vc_data_in;
  logic [VC-1:0]            vc_valid_in;
  logic [VC-1:0]            vc_ready_in;
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     valid_out;
  logic                     ready_out;
  logic [ID_W-1:0]          vc_id_out;

  // master: the VC sources plus the router side; slave: the arbiter.
  modport master (
    output vc_data_in, vc_valid_in, ready_out,
    input  vc_ready_in, data_out, valid_out, vc_id_out
  );

  modport slave (
    input  vc_data_in, vc_valid_in, ready_out,
    output vc_ready_in, data_out, valid_out, vc_id_out
  );

endinterface

// File: rtl/vc_injection_arbiter_rr_priority_picker.sv
// Combinational round-robin search: first requester at or above ptr_i,
// wrapping modulo N. Returns one-hot grant, its index and an any flag.
module rr_priority_picker #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] request_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] grant_idx_o,
  output logic         any_o
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    idx         = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!any_o && request_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = W'(idx);
      end
    end
  end

endmodule

// File: rtl/vc_injection_arbiter.sv
// Round-robin VC injection arbiter feeding one registered output flit.
// Define VC_PACKET_LOCK_EN to hold the grant on one VC from head to tail.
module vc_injection_arbiter
  import noc_pkg::*;
#(
  parameter int VC         = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  vc_injection_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(VC);

  logic [VC-1:0]         req;
  logic [VC-1:0]         pick_grant;
  logic [ID_W-1:0]       pick_idx;
  logic                  pick_any;
  logic                  can_load;
  logic                  load;
  logic [DATA_WIDTH-1:0] sel_data;

  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ID_W-1:0]       vc_q;
  logic                  valid_q;

`ifdef VC_PACKET_LOCK_EN
  lock_state_e     state_q, state_d;
  logic [ID_W-1:0] lock_vc_q, lock_vc_d;
  logic [1:0]      sel_type;

  // While locked only the owning VC may compete; the pointer is irrelevant.
  always_comb begin
    req = bus.vc_valid_in;
    if (state_q == LOCK_LOCKED) begin
      req = bus.vc_valid_in & ({{(VC-1){1'b0}}, 1'b1} << lock_vc_q);
    end
  end

  assign sel_type = sel_data[FLIT_TYPE_MSB:FLIT_TYPE_LSB];

  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    if (load) begin
      unique case (state_q)
        LOCK_IDLE: begin
          if (is_head(sel_type)) begin
            state_d   = LOCK_LOCKED;
            lock_vc_d = pick_idx;
          end
        end
        LOCK_LOCKED: begin
          if (is_tail(sel_type)) state_d = LOCK_IDLE;
        end
        default: state_d = LOCK_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOCK_IDLE;
      lock_vc_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_vc_q <= lock_vc_d;
    end
  end
`else
  assign req = bus.vc_valid_in;
`endif

  rr_priority_picker #(.N(VC)) u_picker (
    .request_i   (req),
    .ptr_i       (ptr_q),
    .grant_o     (pick_grant),
    .grant_idx_o (pick_idx),
    .any_o       (pick_any)
  );

  // Accept only into an empty or draining register, and never during reset.
  assign can_load        = (~valid_q | bus.ready_out) & ~rst;
  assign load            = can_load & pick_any;
  assign bus.vc_ready_in = load ? pick_grant : '0;

  assign sel_data = bus.vc_data_in[pick_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = (pick_idx == ID_W'(VC - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      vc_q    <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (load) begin
        valid_q <= 1'b1;
        data_q  <= sel_data;
        vc_q    <= pick_idx;
      end else if (bus.ready_out) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.vc_id_out = vc_q;

endmodule

// File: tb/tb_vc_injection_arbiter.sv
// Directed bench for vc_injection_arbiter: per-VC source queues drive the
// inputs, an in-order scoreboard checks every flit leaving the register.
module tb_vc_injection_arbiter;
  import noc_pkg::*;

  localparam int VC = 4;
  localparam int DW = 32;

  typedef struct packed {
    logic [1:0]  vc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vc_injection_arbiter_if #(.VC(VC), .DATA_WIDTH(DW)) bus ();

  vc_injection_arbiter #(.VC(VC), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] src_q[VC][$];
  logic [VC-1:0] src_en;
  logic [VC-1:0] last_grant;
  logic        rdy;
  bit          mon_en;

  function automatic logic [31:0] mk(input logic [1:0] t, input int k, input int j);
    return {t, 22'b0, 4'(k), 4'(j)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_flit(input int k, input logic [31:0] d);
    src_q[k].push_back(d);
    sb.push_back('{vc: 2'(k), data: d});
  endtask

  task automatic drive();
    logic [VC*DW-1:0] d;
    logic [VC-1:0]    v;
    d = '0;
    v = '0;
    for (int k = 0; k < VC; k++) begin
      if (src_q[k].size() > 0) begin
        d[k*DW +: DW] = src_q[k][0];
        v[k]          = src_en[k];
      end
    end
    bus.vc_data_in  = d;
    bus.vc_valid_in = v;
    bus.ready_out   = rdy;
  endtask

  // One clock: sample at negedge (transfer + grant), advance, update sources.
  task automatic step();
    exp_t e;
    @(negedge clk);
    last_grant = bus.vc_ready_in;
    check("ready_onehot0", 64'($onehot0(last_grant)), 64'd1);
    if (mon_en && bus.valid_out && bus.ready_out) begin
      if (sb.size() > 0) e = sb.pop_front();
      else begin
        e.vc   = 'x;
        e.data = 'x;
      end
      check("mon_vc", 64'(bus.vc_id_out), 64'(e.vc));
      check("mon_data", 64'(bus.data_out), 64'(e.data));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < VC; k++) begin
      if (last_grant[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    end
    drive();
  endtask

  initial begin
    logic [31:0] t2 [3];
    src_en = '1;
    rdy    = 1'b0;
    mon_en = 1'b1;
    bus.vc_data_in  = '1;
    bus.vc_valid_in = '1;
    bus.ready_out   = 1'b0;

    // Reset state, with every VC requesting.
    #12;
    check("rst_valid", 64'(bus.valid_out), 64'd0);
    check("rst_data", 64'(bus.data_out), 64'd0);
    check("rst_vcid", 64'(bus.vc_id_out), 64'd0);
    check("rst_ready_in", 64'(bus.vc_ready_in), 64'd0);

    // All VCs valid, ready high: 0,1,2,3,0,1,2,3 back to back from VC 0.
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < VC; k++) add_flit(k, mk(2'b10, k, r));
    rdy = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    for (int i = 0; i < 8; i++) begin
      step();
      check("t1_valid", 64'(bus.valid_out), 64'd1);
      check("t1_vcid", 64'(bus.vc_id_out), 64'(i % 4));
    end
    step();
    check("t1_drained", 64'(bus.valid_out), 64'd0);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Only VC 2 valid, a head/body/tail packet on consecutive cycles.
    t2[0] = 32'h4000_0001;
    t2[1] = 32'h0000_0002;
    t2[2] = 32'hC000_0003;
    for (int i = 0; i < 3; i++) add_flit(2, t2[i]);
    drive();
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_valid", 64'(bus.valid_out), 64'd1);
      check("t2_vcid", 64'(bus.vc_id_out), 64'd2);
      check("t2_data", 64'(bus.data_out), 64'(t2[i]));
    end
    step();
    check("t2_drained", 64'(bus.valid_out), 64'd0);

    // Backpressure: pointer sits at 3 so VC 3 loads first, then 5 stalled cycles.
    rdy = 1'b0;
    add_flit(3, 32'h8000_0C03);
    add_flit(1, 32'h8000_0A01);
    add_flit(1, 32'h8000_0B01);
    src_q[3].delete();
    src_q[1].delete();
    src_q[1].push_back(32'h8000_0A01);
    src_q[1].push_back(32'h8000_0B01);
    src_q[3].push_back(32'h8000_0C03);
    drive();
    step();
    check("t3_load_vcid", 64'(bus.vc_id_out), 64'd3);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_no_ready_in", 64'(last_grant), 64'd0);
      check("t3_hold_valid", 64'(bus.valid_out), 64'd1);
      check("t3_hold_data", 64'(bus.data_out), 64'h8000_0C03);
      check("t3_hold_vcid", 64'(bus.vc_id_out), 64'd3);
    end
    rdy = 1'b1;
    drive();
    for (int i = 0; i < 3; i++) step();
    check("t3_drained", 64'(bus.valid_out), 64'd0);
    check("t3_sb_empty", 64'(sb.size()), 64'd0);
    check("t3_src_empty", 64'(src_q[1].size() + src_q[3].size()), 64'd0);

`ifdef VC_PACKET_LOCK_EN
    // Lock: VC 1 head taken, VC 1 then idles 3 cycles while VC 3 waits.
    src_en = 4'b0010;
    add_flit(1, mk(FLIT_HEAD, 1, 0));
    add_flit(1, mk(2'b10, 1, 1));
    add_flit(1, mk(FLIT_TAIL, 1, 2));
    add_flit(3, mk(2'b10, 3, 0));
    drive();
    step();
    check("lk_head_vcid", 64'(bus.vc_id_out), 64'd1);
    src_en = 4'b1000;
    drive();
    for (int i = 0; i < 3; i++) begin
      step();
      check("lk_no_grant", 64'(last_grant), 64'd0);
    end
    src_en = '1;
    drive();
    step();
    check("lk_body_vcid", 64'(bus.vc_id_out), 64'd1);
    step();
    check("lk_tail_data", 64'(bus.data_out), 64'(mk(FLIT_TAIL, 1, 2)));
    step();
    check("lk_vc3_after", 64'(bus.vc_id_out), 64'd3);
    step();
    check("lk_drained", 64'(bus.valid_out), 64'd0);
    check("lk_sb_empty", 64'(sb.size()), 64'd0);
`else
    // No lock: two concurrent 4-flit packets interleave per flit, VC 0 first.
    for (int j = 0; j < 4; j++) begin
      logic [1:0] t;
      t = (j == 0) ? FLIT_HEAD : (j == 3) ? FLIT_TAIL : 2'b10;
      add_flit(0, mk(t, 0, j));
      add_flit(1, mk(t, 1, j));
    end
    drive();
    for (int i = 0; i < 8; i++) begin
      step();
      check("il_valid", 64'(bus.valid_out), 64'd1);
      check("il_vcid", 64'(bus.vc_id_out), 64'(i % 2));
    end
    step();
    check("il_drained", 64'(bus.valid_out), 64'd0);
    check("il_sb_empty", 64'(sb.size()), 64'd0);
`endif

    // Reset mid-stream: pointer left at 2, register full.
    mon_en = 1'b0;
    src_q[0].push_back(mk(2'b10, 0, 4));
    src_q[1].push_back(mk(2'b10, 1, 4));
    src_q[2].push_back(mk(2'b10, 2, 4));
    drive();
    step();
    step();
    check("t5_pre_valid", 64'(bus.valid_out), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 64'(bus.valid_out), 64'd0);
    check("t5_rst_data", 64'(bus.data_out), 64'd0);
    check("t5_rst_vcid", 64'(bus.vc_id_out), 64'd0);
    check("t5_rst_ready_in", 64'(bus.vc_ready_in), 64'd0);
    for (int k = 0; k < VC; k++) src_q[k].delete();
    sb.delete();
    @(posedge clk);
    #1;
    for (int k = 0; k < VC; k++) add_flit(k, mk(2'b10, k, 6));
    mon_en = 1'b1;
    rst    = 1'b0;
    drive();
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_vcid", 64'(bus.vc_id_out), 64'(i));
    end
    step();
    check("t5_drained", 64'(bus.valid_out), 64'd0);
    check("t5_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
